// File: rtl/led_sequencer.sv
// led_sequencer: boot fill animation, LED7 heartbeat and timed host byte display on the 8-LED bank
module led_sequencer #(
  parameter int STEP_TICKS      = 1_200_000,
  parameter int HOLD_TICKS      = 6_000_000,
  parameter int HEARTBEAT_TICKS = 6_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  output logic       host_ready,
  input  logic       replay,
  output logic [7:0] leds,
  output logic [1:0] state
);
  localparam int MAX_SH = STEP_TICKS > HOLD_TICKS ? STEP_TICKS : HOLD_TICKS;
  localparam int MAX_T  = MAX_SH > HEARTBEAT_TICKS ? MAX_SH : HEARTBEAT_TICKS;
  localparam int W      = MAX_T > 1 ? $clog2(MAX_T) : 1;
  typedef enum logic [1:0] {ANIM = 2'd0, IDLE = 2'd1, SHOW = 2'd2} state_e;
  state_e       state_q, state_d;
  logic [7:0]   leds_q, leds_d;
  logic [W-1:0] cnt_q, cnt_d, last;
  logic         ev, xfer;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ANIM;
      leds_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      cnt_q   <= cnt_d;
    end
  end
  // replay outranks a transfer, and a transfer outranks any same-edge timer event
  always_comb begin
    last    = state_q == ANIM ? W'(STEP_TICKS - 1)
            : state_q == IDLE ? W'(HEARTBEAT_TICKS - 1) : W'(HOLD_TICKS - 1);
    ev      = cnt_q == last;
    xfer    = host_valid && host_ready;
    state_d = state_q;
    leds_d  = leds_q;
    cnt_d   = ev ? '0 : cnt_q + W'(1);
    if (replay && state_q != ANIM) begin
      state_d = ANIM;
      leds_d  = 8'h00;
      cnt_d   = '0;
    end else if (xfer) begin
      state_d = SHOW;
      leds_d  = host_data;
      cnt_d   = '0;
    end else if (ev) begin
      if (state_q == ANIM) begin
        state_d = leds_q == 8'hFF ? IDLE : ANIM;
        leds_d  = leds_q == 8'hFF ? 8'h00 : {leds_q[6:0], 1'b1};
      end else if (state_q == IDLE) begin
        leds_d  = {~leds_q[7], 7'h00};
      end else begin
        state_d = IDLE;
        leds_d  = 8'h00;
      end
    end
  end
  always_comb begin
    host_ready = state_q != ANIM && !replay;
    leds       = leds_q;
    state      = state_q;
  end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed and randomized checks of led_sequencer against a behavioural model
module tb_led_sequencer;
  localparam int STEP = 4, HOLD = 10, HB = 5;
  logic       clock = 1'b0, reset_n = 1'b0, host_valid = 1'b0, replay = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic       host_ready;
  logic [7:0] leds;
  logic [1:0] state;
  int         checks = 0, passed = 0;
  int         m_mode = 0, m_k = 0, m_el = 0;
  logic [7:0] m_leds = 8'h00;
  logic       obs_rdy, exp_rdy;

  led_sequencer #(.STEP_TICKS(STEP), .HOLD_TICKS(HOLD), .HEARTBEAT_TICKS(HB)) dut (
    .clock(clock), .reset_n(reset_n), .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready), .replay(replay), .leds(leds), .state(state)
  );

  always #5 clock = ~clock;

  function automatic int period(input int md);
    return md == 0 ? STEP : md == 1 ? HB : HOLD;
  endfunction

  // mode 0=ANIM 1=IDLE 2=SHOW; m_k counts completed animation steps, m_el edges since timer restart
  task automatic model_edge(input logic rn, input logic v, input logic [7:0] d, input logic rp);
    if (!rn || (rp && m_mode != 0)) begin
      m_mode = 0; m_k = 0; m_leds = 8'h00; m_el = 0;
    end else if (v && m_mode != 0) begin
      m_mode = 2; m_leds = d; m_el = 0;
    end else begin
      m_el++;
      if (m_el == period(m_mode)) begin
        m_el = 0;
        if (m_mode == 0) begin
          m_k++;
          if (m_k == 9) begin m_mode = 1; m_leds = 8'h00; end
          else m_leds = 8'((1 << m_k) - 1);
        end else if (m_mode == 1) m_leds[7] = ~m_leds[7];
        else begin m_mode = 1; m_leds = 8'h00; end
      end
    end
  endtask

  // one clock: drive, sample ready mid-cycle, advance DUT and model, settle 1 after the edge
  task automatic step(input logic rn, input logic v, input logic [7:0] d, input logic rp);
    reset_n = rn; host_valid = v; host_data = d; replay = rp;
    @(negedge clock);
    obs_rdy = host_ready;
    exp_rdy = m_mode != 0 && !rp;
    @(posedge clock);
    model_edge(rn, v, d, rp);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
      checks++;
      if (leds !== 8'h00 || state !== 2'd0 || obs_rdy !== 1'b0)
        $display("FAIL reset: leds=%h state=%0d ready=%b, want 00 0 0", leds, state, obs_rdy);
      else passed++;
    end
  endtask

  task automatic test_boot();
    for (int i = 1; i <= 36; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (leds !== m_leds || state !== 2'(m_mode) || obs_rdy !== 1'b0)
        $display("FAIL boot_model i=%0d: leds=%h state=%0d ready=%b, want %h %0d 0", i, leds, state, obs_rdy, m_leds, m_mode);
      else passed++;
      if (i % 4 == 0 && i <= 32) begin
        checks++;
        if (leds !== 8'((1 << (i / 4)) - 1) || state !== 2'd0)
          $display("FAIL boot_fill i=%0d: leds=%h state=%0d, want %h 0", i, leds, state, 8'((1 << (i / 4)) - 1));
        else passed++;
      end
    end
    checks++;
    if (leds !== 8'h00 || state !== 2'd1)
      $display("FAIL boot_done: leds=%h state=%0d, want 00 1", leds, state);
    else passed++;
  endtask

  task automatic test_heartbeat();
    for (int j = 1; j <= 20; j++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (leds !== m_leds || state !== 2'(m_mode) || obs_rdy !== exp_rdy)
        $display("FAIL hb_model j=%0d: leds=%h state=%0d ready=%b, want %h %0d %b", j, leds, state, obs_rdy, m_leds, m_mode, exp_rdy);
      else passed++;
      if (j % 5 == 0) begin
        checks++;
        if (leds !== (((j / 5) % 2) == 1 ? 8'h80 : 8'h00) || state !== 2'd1)
          $display("FAIL heartbeat j=%0d: leds=%h state=%0d, want %h 1", j, leds, state, ((j / 5) % 2) == 1 ? 8'h80 : 8'h00);
        else passed++;
      end
    end
  endtask

  task automatic test_show();
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    checks++;
    if (leds !== 8'hA5 || state !== 2'd2 || obs_rdy !== 1'b1)
      $display("FAIL show_accept: leds=%h state=%0d ready=%b, want a5 2 1", leds, state, obs_rdy);
    else passed++;
    for (int t = 1; t <= 10; t++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (t < 10 ? (leds !== 8'hA5 || state !== 2'd2) : (leds !== 8'h00 || state !== 2'd1))
        $display("FAIL show_hold t=%0d: leds=%h state=%0d", t, leds, state);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    for (int t = 1; t <= 5; t++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    checks++;
    if (leds !== 8'h3C || state !== 2'd2)
      $display("FAIL rewrite: leds=%h state=%0d, want 3c 2", leds, state);
    else passed++;
    for (int t = 1; t <= 10; t++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (t < 10 ? (leds !== 8'h3C || state !== 2'd2) : (leds !== 8'h00 || state !== 2'd1))
        $display("FAIL rewrite_hold t=%0d: leds=%h state=%0d", t, leds, state);
      else passed++;
    end
  endtask

  task automatic test_replay_collision();
    step(1'b1, 1'b1, 8'h11, 1'b1);
    checks++;
    if (leds !== 8'h00 || state !== 2'd0 || obs_rdy !== 1'b0)
      $display("FAIL replay_wins: leds=%h state=%0d ready=%b, want 00 0 0", leds, state, obs_rdy);
    else passed++;
    for (int t = 1; t <= 36; t++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'($urandom));
      if (t == 4) begin
        checks++;
        if (leds !== 8'h01 || state !== 2'd0)
          $display("FAIL replay_first_step: leds=%h state=%0d, want 01 0", leds, state);
        else passed++;
      end
    end
    checks++;
    if (leds !== 8'h00 || state !== 2'd1)
      $display("FAIL replay_done: leds=%h state=%0d, want 00 1", leds, state);
    else passed++;
  endtask

  task automatic test_valid_held();
    int stalls = 0;
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    for (int i = 1; i <= 36; i++) begin
      step(1'b1, 1'b1, 8'h5A, 1'b0);
      if (obs_rdy !== 1'b0) stalls++;
    end
    checks++;
    if (stalls != 0 || leds !== 8'h00 || state !== 2'd1)
      $display("FAIL held_stall: early_ready=%0d leds=%h state=%0d, want 0 00 1", stalls, leds, state);
    else passed++;
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    checks++;
    if (obs_rdy !== 1'b1 || leds !== 8'h5A || state !== 2'd2)
      $display("FAIL held_accept: ready=%b leds=%h state=%0d, want 1 5a 2", obs_rdy, leds, state);
    else passed++;
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    checks++;
    if (leds !== 8'hC3 || state !== 2'd2)
      $display("FAIL held_again: leds=%h state=%0d, want c3 2", leds, state);
    else passed++;
    step(1'b0, 1'b1, 8'h77, 1'b0);
    checks++;
    if (leds !== 8'h00 || state !== 2'd0)
      $display("FAIL mid_show_reset: leds=%h state=%0d, want 00 0", leds, state);
    else passed++;
    step(1'b1, 1'b1, 8'h77, 1'b0);
    checks++;
    if (obs_rdy !== 1'b0 || leds !== 8'h00)
      $display("FAIL post_reset_stall: ready=%b leds=%h, want 0 00", obs_rdy, leds);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(63) != 0, $urandom_range(2) == 0, 8'($urandom), $urandom_range(15) == 0);
      checks++;
      if (leds !== m_leds || state !== 2'(m_mode) || obs_rdy !== exp_rdy)
        $display("FAIL random i=%0d: leds=%h state=%0d ready=%b, want %h %0d %b", i, leds, state, obs_rdy, m_leds, m_mode, exp_rdy);
      else passed++;
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_boot();
    test_heartbeat();
    test_show();
    test_back_to_back();
    test_replay_collision();
    test_valid_held();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Owns the 8-LED bank on the bifröst board and decides what drives it.
- On reset it plays a fill-in boot animation, then idles with a heartbeat on LED7.
- Any requester, such as the CPU debug register, can display a byte for a fixed hold time through a valid/ready handshake.
- A replay pulse re-runs the boot animation.

Parameters:
- STEP_TICKS, 1_200_000, clock cycles per animation step (100 ms at 12 MHz).
- HOLD_TICKS, 6_000_000, clock cycles a host byte stays displayed after its last write.
- HEARTBEAT_TICKS, 6_000_000, clock cycles between heartbeat toggles of LED7.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset_n  input  1  synchronous active-low reset.
- host_valid  input  1  host presents a display byte.
- host_data  input  8  byte to display.
- host_ready  output  1  combinational; a transfer occurs on the posedge where host_valid and host_ready are both 1.
- replay  input  1  single-cycle request to restart the boot animation.
- leds  output  8  LED drive, 1 = lit, registered.
- state  output  2  current state: 0=ANIM, 1=IDLE, 2=SHOW.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset_n low at posedge): state=ANIM, leds=8'h00, tick counter=0.
- Tick counter: width is clog2 of the largest parameter. It increments every cycle. An "event" fires on the edge where counter == N-1 for the current state's N; the counter then returns to 0.
- Every state transition and every accepted transfer clears the counter to 0 on that edge.
- host_ready = (state != ANIM) && !replay. The host is stalled during the animation, and replay wins over a same-cycle write.
- ANIM (N=STEP_TICKS):
  - Each event: if leds != 8'hFF then leds <= {leds[6:0],1'b1}; else leds <= 8'h00 and state <= IDLE.
  - The full animation is 9 events = 9*STEP_TICKS cycles.
  - After reset release, leds==8'h01 after exactly STEP_TICKS clocks.
  - replay is ignored while in ANIM.
- IDLE (N=HEARTBEAT_TICKS):
  - leds[6:0]=0.
  - Each event toggles leds[7]. Entry always sets leds=8'h00.
- SHOW (N=HOLD_TICKS):
  - leds hold the last accepted byte.
  - An event sets leds <= 8'h00 and state <= IDLE.
- Transfer (IDLE or SHOW): next edge leds <= host_data, state <= SHOW, counter <= 0. A write during SHOW restarts the hold window.
- replay asserted in IDLE or SHOW: next edge state <= ANIM, leds <= 8'h00, counter <= 0.
- Simultaneous events:
  - replay together with host_valid: no transfer; replay is taken.
  - A transfer on the same edge as a SHOW expiry or heartbeat event: the transfer wins and leds show host_data.
- host_valid may stay high across cycles. Each cycle with valid&&ready is a separate transfer, so the hold window keeps restarting.
- Reset mid-operation: an immediate return to the reset values on the next posedge regardless of state. A pending host request is dropped and host_ready is 0 until the animation completes.
- No other outputs. leds never change except on an event, a transfer, replay, or reset.

Test Plan:
Bench parameters: STEP_TICKS=4, HOLD_TICKS=10, HEARTBEAT_TICKS=5.
- Reset, then release and run 40 clocks -> leds 01,03,07,...,FF each 4 clocks apart at clocks 4..32; leds=00 and state=IDLE at clock 36; host_ready=0 throughout ANIM.
- In IDLE with no stimulus for 20 clocks -> leds alternate 00/80 every 5 clocks.
- Single-cycle host_valid with host_data=8'hA5 in IDLE -> leds=A5 and state=SHOW next clock; leds=00 and state=IDLE exactly 10 clocks later.
- Second write of 8'h3C 6 clocks into SHOW -> leds=3C; expiry occurs 10 clocks after the second write, not the first.
- host_valid with 8'h11 and replay asserted in the same IDLE cycle -> no transfer; leds=00 and state=ANIM next clock; leds=01 4 clocks later.
- Hold host_valid high from reset release -> host_ready stays 0 until IDLE at clock 36; transfer accepted that cycle; assert reset_n=0 mid-SHOW -> leds=00 and state=ANIM on the next posedge.
